// File: rtl/mips_mem_port_arbiter.sv
// ============================================================================
// Module   : mips_mem_port_arbiter
// Purpose  : Shares one single-ported unified memory between the IF (read-only)
//            and MEM (read/write) pipeline requesters. Fixed-latency access
//            sequencing, MEM priority with an IF anti-starvation limit, and a
//            pipeline-wide stall.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mips_mem_port_arbiter #(
  parameter int ADDR_W        = 32,
  parameter int DATA_W        = 32,
  parameter int WAIT_CYCLES   = 2,
  parameter int IF_STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ack,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              mem_req,
  input  logic              mem_we,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic              mem_ack,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              m_en,
  output logic              m_we,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic [DATA_W-1:0] m_rdata,
  output logic              stall,
  output logic              busy
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_RESP   = 2'd2;

  localparam logic [3:0] WAIT_LOAD  = 4'(WAIT_CYCLES - 1);
  localparam logic [3:0] STARVE_LIM = 4'(IF_STARVE_MAX);

  logic [1:0]        state_q, state_d;
  logic [3:0]        wait_q, wait_d;
  logic [3:0]        starve_q, starve_d;
  logic              owner_mem_q, owner_mem_d;   // 1 = MEM owns the access
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] mem_rdata_q, mem_rdata_d;
  logic              grant_mem;

  // MEM wins unless IF has been passed over IF_STARVE_MAX times in a row
  assign grant_mem = mem_req & ~(if_req & (starve_q == STARVE_LIM));

  // Next-state logic: grant/latch in IDLE, count down in ACCESS, ack in RESP
  always_comb begin
    state_d     = state_q;
    wait_d      = wait_q;
    starve_d    = starve_q;
    owner_mem_d = owner_mem_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    if_rdata_d  = if_rdata_q;
    mem_rdata_d = mem_rdata_q;
    case (state_q)
      S_IDLE: begin
        if (if_req | mem_req) begin
          state_d     = S_ACCESS;
          wait_d      = WAIT_LOAD;
          owner_mem_d = grant_mem;
          if (grant_mem) begin
            we_d    = mem_we;
            addr_d  = mem_addr;
            wdata_d = mem_wdata;
            if (if_req) begin
              starve_d = (starve_q == 4'd15) ? 4'd15 : starve_q + 4'd1;
            end else begin
              starve_d = 4'd0;
            end
          end else begin
            we_d     = 1'b0;
            addr_d   = if_addr;
            starve_d = 4'd0;
          end
        end
      end
      S_ACCESS: begin
        if (wait_q == 4'd0) begin
          state_d = S_RESP;
          // Read data is only meaningful in the final access cycle
          if (!we_q) begin
            if (owner_mem_q) begin
              mem_rdata_d = m_rdata;
            end else begin
              if_rdata_d = m_rdata;
            end
          end
        end else begin
          wait_d = wait_q - 4'd1;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any access in flight
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      wait_q      <= 4'd0;
      starve_q    <= 4'd0;
      owner_mem_q <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      if_rdata_q  <= '0;
      mem_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      wait_q      <= wait_d;
      starve_q    <= starve_d;
      owner_mem_q <= owner_mem_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      if_rdata_q  <= if_rdata_d;
      mem_rdata_q <= mem_rdata_d;
    end
  end

  assign m_en      = (state_q == S_ACCESS);
  assign m_we      = m_en & we_q;
  assign m_addr    = addr_q;
  assign m_wdata   = wdata_q;
  assign if_ack    = (state_q == S_RESP) & ~owner_mem_q;
  assign mem_ack   = (state_q == S_RESP) & owner_mem_q;
  assign if_rdata  = if_rdata_q;
  assign mem_rdata = mem_rdata_q;
  assign busy      = (state_q != S_IDLE);
  assign stall     = (if_req & ~if_ack) | (mem_req & ~mem_ack);

endmodule

`default_nettype wire

// File: doc/mips_mem_port_arbiter.md
Name: mips_mem_port_arbiter

Overview:
- Shares one single-ported unified memory between the pipeline's instruction-fetch requester (IF, read-only) and data-access requester (MEM, read/write).
- Sits between the IF/MEM pipeline stages and the memory macro.
- Sequences fixed-latency memory accesses with a small FSM and wait counter.
- Arbitrates with MEM priority plus an IF anti-starvation limit, and produces a pipeline-wide stall.

Parameters:
- ADDR_W, 32, address width of all address ports.
- DATA_W, 32, data width of all data ports.
- WAIT_CYCLES, 2, cycles the memory needs per access; legal range 1..15.
- IF_STARVE_MAX, 4, consecutive MEM grants allowed while IF waits before IF is forced; legal range 1..15.

Ports:
- clk  in  1  clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- if_req  in  1  IF read request, level; held until if_ack.
- if_addr  in  ADDR_W  IF read address; stable while if_req=1.
- if_ack  out  1  one-cycle pulse: IF access complete, if_rdata valid.
- if_rdata  out  DATA_W  IF read data, registered; held until the next IF ack.
- mem_req  in  1  MEM request, level; held until mem_ack.
- mem_we  in  1  1=write, 0=read; stable while mem_req=1.
- mem_addr  in  ADDR_W  MEM address.
- mem_wdata  in  DATA_W  MEM write data.
- mem_ack  out  1  one-cycle pulse: MEM access complete.
- mem_rdata  out  DATA_W  MEM read data, registered; unchanged by writes.
- m_en  out  1  memory enable; high for the whole access.
- m_we  out  1  memory write enable.
- m_addr  out  ADDR_W  memory address, latched.
- m_wdata  out  DATA_W  memory write data, latched.
- m_rdata  in  DATA_W  memory read data; valid in the last ACCESS cycle.
- stall  out  1  pipeline freeze request, combinational.
- busy  out  1  FSM not in IDLE.

Behaviour:
- Reset (synchronous, active-high, priority over everything):
  - State=IDLE; wait counter and starve counter =0.
  - Outputs if_ack, mem_ack, m_en, m_we, busy =0; m_addr, m_wdata, if_rdata, mem_rdata =0.
  - Reset mid-access aborts it: m_en=0 from the next edge, no ack issued, requesters re-issue.
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - If neither request is pending, stay in IDLE.
  - Otherwise grant one owner, latch the owner's addr/wdata/we into m_addr/m_wdata/m_we, load wait counter=WAIT_CYCLES-1, and go to ACCESS.
- Grant rule:
  - If mem_req=1, grant MEM, unless if_req=1 and starve counter==IF_STARVE_MAX, in which case grant IF.
  - If only if_req=1, grant IF.
- Starve counter:
  - MEM grant with if_req=1: increment, saturating at 15.
  - Any IF grant, or a MEM grant with if_req=0: clear.
- ACCESS:
  - m_en=1, m_we=latched we (IF grant forces 0).
  - Counter decrements each cycle.
  - In the cycle the counter is 0: capture m_rdata into the owner's rdata register (reads only), go to RESP.
- RESP:
  - Owner's ack=1 for exactly this cycle; m_en=0, m_we=0.
  - Always return to IDLE; no back-to-back grant from RESP.
- Latency: request first seen in IDLE at cycle t gives ACCESS t+1..t+WAIT_CYCLES and ack at t+WAIT_CYCLES+1. With WAIT_CYCLES=2, ack arrives at t+3.
- Requester protocol:
  - Deassert req in the cycle after ack, or present the next request.
  - A req high while in IDLE is always a new request.
  - Input changes during ACCESS are ignored, since values are latched.
- Simultaneous requests: exactly one is granted; the loser stays pending and is arbitrated in the next IDLE.
- stall = (if_req & ~if_ack) | (mem_req & ~mem_ack).
- busy = (state != IDLE).
- if_ack and mem_ack are never high in the same cycle.
- Addresses pass through unchanged; word alignment is the requester's responsibility.
- if_rdata and mem_rdata change only on their own port's read completion.

Test Plan:
- Reset, then IF read if_addr=0x40 with m_rdata=0x20080005 → m_en high 2 cycles, if_ack at t+3, if_rdata=0x20080005, stall=1 on t..t+2 and 0 at t+3.
- MEM write mem_addr=0x10, mem_wdata=0xDEADBEEF → m_we=1 for 2 cycles with m_addr=0x10, mem_ack at t+3, mem_rdata unchanged.
- if_req and mem_req rise together → MEM granted first (mem_ack at t+3); IF granted in the following IDLE (if_ack at t+7); acks never overlap.
- if_req held high, mem_req re-issued immediately after every ack, IF_STARVE_MAX=4 → 4 MEM acks, then IF ack, then starve counter reads 0.
- reset asserted in the 2nd ACCESS cycle of a MEM read → next edge: IDLE, m_en=0, no mem_ack, mem_rdata=0.
- WAIT_CYCLES=1, single IF read → ack at t+2; m_en high exactly 1 cycle.
